// File: rtl/ps2_key_decoder_pkg.sv
// Shared definitions for the PS/2 key decoder: scan-code set 2 constants,
// frame FSM state encoding, held-key payload struct and a parity helper.
package ps2_key_decoder_pkg;

  // Game-control scan codes (set 2, non-extended)
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_Z     = 8'h1A;
  localparam logic [7:0] SC_X     = 8'h22;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  // Prefix bytes
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Extended arrow-key codes (follow an E0 prefix)
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Frame FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // Held-key levels
  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic shoot;
    logic bomb;
    logic enter;
  } key_levels_t;

  // Odd parity across data plus parity bit
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises ps2_clk/ps2_data, detects ps2_clk falling
// edges, runs the start/data/parity/stop FSM and abandons stalled frames.
// Ports: clk, rstn (async active-low), clear (sync soft clear), ps2_clk,
//        ps2_data (async raw lines); byte_valid/byte_data (one-cycle good
//        byte), frame_err (one-cycle parity/stop/timeout error).
module ps2_frame_rx
  import ps2_key_decoder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clear,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q;
  logic [1:0]             state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_ok_q, par_ok_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   byte_valid_d, frame_err_d;
  logic [7:0]             byte_data_d;
  logic                   clk_s, data_s, fall;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_s;

  // Synchronisers reset to the idle-high line level
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_s;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_ok_q   <= 1'b0;
      cnt_q      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_ok_q   <= par_ok_d;
      cnt_q      <= cnt_d;
      byte_valid <= byte_valid_d;
      byte_data  <= byte_data_d;
      frame_err  <= frame_err_d;
    end
  end

  // Next-state logic; a same-cycle edge pre-empts the timeout
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_ok_d     = par_ok_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data;
    frame_err_d  = 1'b0;
    cnt_d        = cnt_q + CNT_W'(1);
    if (state_q == ST_IDLE || fall) cnt_d = '0;

    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_ok_d = odd_parity_ok(shift_q, data_s);
          state_d  = ST_STOP;
        end
        default: begin
          if (data_s && par_ok_q) begin
            byte_valid_d = 1'b1;
            byte_data_d  = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
      cnt_d       = '0;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 decoder: tracks F0/E0 prefixes over received bytes and
// maintains held-key levels for the game controls plus a last-code report.
// Ports: clk, rstn (async active-low), clear (sync soft clear), ps2_clk,
//        ps2_data; key_* held levels, key_event pulse, last_code/last_ext/
//        last_break report, frame_err pulse.
// Build option: define ARROW_KEYS_EN to let extended arrow keys drive the
// direction outputs alongside WASD.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clear,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_up,
  output logic       key_down,
  output logic       key_left,
  output logic       key_right,
  output logic       key_shoot,
  output logic       key_bomb,
  output logic       key_enter,
  output logic       key_event,
  output logic [7:0] last_code,
  output logic       last_ext,
  output logic       last_break,
  output logic       frame_err
);

  logic        byte_valid;
  logic [7:0]  byte_data;

  ps2_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (clear),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  key_levels_t held_q, held_d, out_d;
  logic        brk_q, brk_d, ext_q, ext_d;
  logic        key_event_d, last_ext_d, last_break_d;
  logic [7:0]  last_code_d;
  logic        lvl;
`ifdef ARROW_KEYS_EN
  logic [3:0]  arrow_q, arrow_d;  // {up, down, left, right}
`endif

  assign lvl = ~brk_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      held_q     <= '0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      key_event  <= 1'b0;
      last_code  <= '0;
      last_ext   <= 1'b0;
      last_break <= 1'b0;
      {key_up, key_down, key_left, key_right, key_shoot, key_bomb, key_enter} <= '0;
`ifdef ARROW_KEYS_EN
      arrow_q    <= '0;
`endif
    end else begin
      held_q     <= held_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
      key_event  <= key_event_d;
      last_code  <= last_code_d;
      last_ext   <= last_ext_d;
      last_break <= last_break_d;
      {key_up, key_down, key_left, key_right, key_shoot, key_bomb, key_enter} <= out_d;
`ifdef ARROW_KEYS_EN
      arrow_q    <= arrow_d;
`endif
    end
  end

  // Prefix tracking and key mapping; clear overrides any same-cycle byte
  always_comb begin
    held_d       = held_q;
    brk_d        = brk_q;
    ext_d        = ext_q;
    key_event_d  = 1'b0;
    last_code_d  = last_code;
    last_ext_d   = last_ext;
    last_break_d = last_break;
`ifdef ARROW_KEYS_EN
    arrow_d      = arrow_q;
`endif
    if (clear) begin
      held_d = '0;
      brk_d  = 1'b0;
      ext_d  = 1'b0;
`ifdef ARROW_KEYS_EN
      arrow_d = '0;
`endif
    end else if (byte_valid) begin
      if (byte_data == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (byte_data == SC_EXT) begin
        ext_d = 1'b1;
      end else begin
        last_code_d  = byte_data;
        last_ext_d   = ext_q;
        last_break_d = brk_q;
        key_event_d  = 1'b1;
        if (!ext_q) begin
          case (byte_data)
            SC_W:     held_d.up    = lvl;
            SC_S:     held_d.down  = lvl;
            SC_A:     held_d.left  = lvl;
            SC_D:     held_d.right = lvl;
            SC_Z:     held_d.shoot = lvl;
            SC_X:     held_d.bomb  = lvl;
            SC_ENTER: held_d.enter = lvl;
            default: ;
          endcase
        end else begin
          case (byte_data)
            SC_ENTER: held_d.enter = lvl;
`ifdef ARROW_KEYS_EN
            SC_UP:    arrow_d[3]   = lvl;
            SC_DOWN:  arrow_d[2]   = lvl;
            SC_LEFT:  arrow_d[1]   = lvl;
            SC_RIGHT: arrow_d[0]   = lvl;
`endif
            default: ;
          endcase
        end
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end

    out_d = held_d;
`ifdef ARROW_KEYS_EN
    out_d.up    = held_d.up    | arrow_d[3];
    out_d.down  = held_d.down  | arrow_d[2];
    out_d.left  = held_d.left  | arrow_d[1];
    out_d.right = held_d.right | arrow_d[0];
`endif
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: bit-bangs PS/2 frames, queues the
// expected decoded events and compares them as key_event pulses appear.
module tb_ps2_key_decoder;

  localparam int unsigned TO = 600;

  logic       clk = 1'b0, rstn = 1'b0, clear = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic       key_up, key_down, key_left, key_right, key_shoot, key_bomb, key_enter;
  logic       key_event, last_ext, last_break, frame_err;
  logic [7:0] last_code;

  ps2_key_decoder #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn), .clear(clear), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .key_shoot(key_shoot), .key_bomb(key_bomb), .key_enter(key_enter),
    .key_event(key_event), .last_code(last_code), .last_ext(last_ext),
    .last_break(last_break), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0, errors = 0;
  int         cyc = 0, stop_cyc = 0, err_seen = 0, err_exp = 0;
  logic       m_brk = 1'b0, m_ext = 1'b0;
  logic [6:0] m_lvl = '0;  // {up,down,left,right,shoot,bomb,enter}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer and error-pulse counter
  always @(negedge clk) begin
    if (rstn) begin
      if (key_event) begin
        if (sb.size() == 0) begin
          check("spurious_event", {24'd0, last_code}, 32'hFFFF_FFFF);
        end else begin
          mon_e = sb.pop_front();
          check("last_code", {24'd0, last_code}, {24'd0, mon_e.code});
          check("last_ext", {31'd0, last_ext}, {31'd0, mon_e.ext});
          check("last_break", {31'd0, last_break}, {31'd0, mon_e.brk});
          check("latency", cyc - stop_cyc, 4);
        end
      end
      if (frame_err) err_seen++;
    end
  end

  // Reference decode of one good byte
  task automatic model_byte(input logic [7:0] b);
    logic l;
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else begin
      sb.push_back('{b, m_ext, m_brk});
      l = ~m_brk;
      if (!m_ext) begin
        case (b)
          8'h1D: m_lvl[6] = l;
          8'h1B: m_lvl[5] = l;
          8'h1C: m_lvl[4] = l;
          8'h23: m_lvl[3] = l;
          8'h1A: m_lvl[2] = l;
          8'h22: m_lvl[1] = l;
          8'h5A: m_lvl[0] = l;
          default: ;
        endcase
      end else begin
        if (b == 8'h5A) m_lvl[0] = l;
`ifdef ARROW_KEYS_EN
        case (b)
          8'h75: m_lvl[6] = l;
          8'h72: m_lvl[5] = l;
          8'h6B: m_lvl[4] = l;
          8'h74: m_lvl[3] = l;
          default: ;
        endcase
`endif
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  task automatic send_bit(input logic b, input logic is_stop);
    @(negedge clk) ps2_data = b;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    if (is_stop) stop_cyc = cyc;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit((~^b) ^ bad_par, 1'b0);
    send_bit(~bad_stop, 1'b1);
  endtask

  task automatic send_key(input logic [7:0] b);
    model_byte(b);
    send_frame(b, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_lvl"}, {25'd0, key_up, key_down, key_left, key_right, key_shoot, key_bomb, key_enter},
          {25'd0, m_lvl});
    check({tag, "_pending"}, sb.size(), 0);
    check({tag, "_errs"}, err_seen, err_exp);
  endtask

  task automatic pulse_clear();
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    m_lvl = '0;
    m_brk = 1'b0;
    m_ext = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outs", {17'd0, key_up, key_down, key_left, key_right, key_shoot, key_bomb, key_enter,
                         key_event, last_code, last_ext, last_break, frame_err}, 32'd0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    send_key(8'h1D);                       check_state("make_up");
    send_key(8'hF0); send_key(8'h1D);      check_state("break_up");

    send_frame(8'h1A, 1'b1, 1'b0); err_exp++; repeat (5) @(negedge clk);
    check_state("bad_parity");
    send_frame(8'h1B, 1'b0, 1'b1); err_exp++; repeat (5) @(negedge clk);
    check_state("bad_stop");

    // Partial frame abandoned by timeout
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    repeat (TO + 50) @(negedge clk);
    err_exp++;
    check_state("timeout");
    send_key(8'h22);                       check_state("bomb");

    // Typematic repeat then release
    send_key(8'h1D); send_key(8'h1D);      check_state("typematic");
    send_key(8'hF0); send_key(8'h1D);      check_state("typematic_rel");

    // Extended codes
    send_key(8'hE0); send_key(8'h75);      check_state("ext_up");
    send_key(8'hE0); send_key(8'hF0); send_key(8'h75); check_state("ext_up_rel");
    send_key(8'hE0); send_key(8'h5A);      check_state("kp_enter");
    send_key(8'hF0); send_key(8'h5A);      check_state("enter_rel");

    // Unmapped and E1 codes consume prefixes without touching levels
    send_key(8'h15);
    send_key(8'hF0); send_key(8'hE1);
    send_key(8'h1C);                       check_state("left_after_e1");
    send_key(8'h1B); send_key(8'h23); send_key(8'h1A); check_state("multi_keys");

    // Clear mid-frame: levels drop, FSM idles (no later timeout), no byte
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    pulse_clear();
    repeat (TO + 50) @(negedge clk);
    check_state("clear_mid");
    send_key(8'hF0);
    pulse_clear();
    send_key(8'h1D);                       check_state("clear_prefix");

    // Asynchronous reset mid-frame
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    @(negedge clk) rstn = 1'b0;
    #1;
    check("reset_async", {17'd0, key_up, key_down, key_left, key_right, key_shoot, key_bomb, key_enter,
                          key_event, last_code, last_ext, last_break, frame_err}, 32'd0);
    m_lvl = '0; m_brk = 1'b0; m_ext = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    send_key(8'h1A);                       check_state("after_reset");

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Receives raw PS/2 keyboard frames and decodes scan-code set 2 make/break sequences.
- Produces held-key levels for the game controls (up/down/left/right, shoot, bomb, enter), a last-code report and error pulses.
- Sits directly upstream of the top-level game logic, feeding the FSM, player and laser units.
- Runs entirely in the system clock domain; PS/2 lines are asynchronous inputs.

Parameters:
- SYNC_STAGES, 2: flip-flop synchroniser depth on ps2_clk and ps2_data; legal range 2-4.
- TIMEOUT_CYCLES, 200000: clk cycles without a ps2_clk falling edge before a partial frame is abandoned (2 ms at 100 MHz).

Ports:
- clk  in  1  system clock (100 MHz).
- rstn  in  1  asynchronous active-low reset.
- clear  in  1  synchronous soft clear: held keys, prefix flags and frame FSM to idle.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- key_up, key_down, key_left, key_right  out  1 each  held levels.
- key_shoot, key_bomb, key_enter  out  1 each  held levels.
- key_event  out  1  one-cycle pulse per decoded non-prefix code.
- last_code  out  8  last decoded non-prefix code.
- last_ext  out  1  that code carried an E0 prefix.
- last_break  out  1  that code carried an F0 prefix.
- frame_err  out  1  one-cycle pulse on a parity, stop or timeout error.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. All outputs reset to 0 and the FSM resets to IDLE.
- Sampling: both PS/2 lines pass through SYNC_STAGES flops. A falling edge is detected when the registered previous value is 1 and the current value is 0.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a falling edge with data=0 go to DATA with bit count 0. A falling edge with data=1 is ignored.
  - DATA: each edge shifts the data bit in LSB-first. After the 8th bit go to PARITY.
  - PARITY: odd parity over the 8 data bits plus the parity bit. Record pass/fail and go to STOP.
  - STOP: data must be 1 and parity must have passed; then byte_valid is asserted on the next cycle. Otherwise frame_err pulses and the byte is discarded. Return to IDLE in either case.
- Timeout: the counter clears on every falling edge and in IDLE. In any non-IDLE state, reaching TIMEOUT_CYCLES forces IDLE and pulses frame_err.
  - If a falling edge and the timeout terminal count land in the same cycle, the edge wins.
- Decode layer (acts on byte_valid):
  - F0 sets break_pending.
  - E0 sets ext_pending.
  - Any other byte is a code. Update last_code, last_ext and last_break, pulse key_event, apply the mapping (make sets the level, break clears it), then clear both pending flags.
  - E1 and unmapped codes still clear the flags and pulse key_event, but change no held level.
- Mapping, non-extended only: 1D up, 1B down, 1C left, 23 right, 1A shoot, 22 bomb, 5A enter.
  - An extended 5A (keypad enter) maps to enter as well.
- Latency: edge detected on the stop bit at cycle N; byte_valid at N+1; key levels, key_event and last_* at N+2.
- clear: takes priority over all same-cycle activity. Returns the FSM to IDLE, zeroes held levels and pending flags, and discards any in-flight frame. last_* are retained.
- Reset mid-frame: everything returns to reset values immediately. The next frame is accepted only from a fresh start bit.
- Repeat makes (typematic) re-pulse key_event; the level stays 1.

Optional Feature:
- ARROW_KEYS_EN defined: extended codes E0 75/72/6B/74 drive up/down/left/right.
  - Each direction has a separate held bit, ORed with its WASD counterpart on the output.
- Undefined: extended arrow codes only update last_* and key_event; held levels are unaffected.

Decomposition:
- Shared package holds:
  - Scan-code constants: SC_W, SC_A, SC_S, SC_D, SC_Z, SC_X, SC_ENTER, SC_BREAK, SC_EXT, SC_UP, SC_DOWN, SC_LEFT, SC_RIGHT.
  - The frame FSM state encoding.
- One sub-module, ps2_frame_rx: synchronisers, edge detection, frame FSM and timeout. It outputs byte_valid, byte_data and frame_err.
- The top level of this block holds only the prefix and mapping logic.

Test Plan:
- Frame 1D (start 0, data 1D LSB-first, parity 1, stop 1) -> key_up=1 two cycles after the stop edge; key_event pulse; last_code=1D, last_ext=0, last_break=0.
- Then F0, 1D -> key_up=0; last_break=1; no key_event on the F0 byte.
- Frame 1A with parity bit inverted -> frame_err pulse; key_shoot stays 0; no key_event.
- Start bit plus 4 data bits, then idle for 200000 cycles -> frame_err at timeout; following frame 22 decoded correctly, key_bomb=1.
- E0 75 with macro defined -> key_up=1, last_ext=1; without macro -> key_up=0, last_code=75, key_event pulses.
- 1C make then clear=1 mid-frame of the next byte -> key_left=0, FSM in IDLE; the truncated frame produces no byte; rstn low mid-frame -> all outputs 0 asynchronously.
